// File: rtl/swo_uart_rx.sv
// SWO (NRZ/UART) receiver: synchronises the SWO pin, deserialises frames, and offers bytes on valid/ready.
// Define SWO_RX_GLITCH_FILTER_EN to take every sample as a 3-sample majority vote.
`timescale 1ns/1ps
module swo_uart_rx #(
  parameter int unsigned pDIV_WIDTH = 8
) (
  input  logic                  uart_clk,
  input  logic                  reset_i,
  input  logic                  I_swo,
  input  logic                  I_enable,
  input  logic [pDIV_WIDTH-1:0] I_bitrate_div,
  input  logic [1:0]            I_stop_bits,
  input  logic [3:0]            I_data_bits,
  input  logic                  I_ready,
  input  logic                  I_clear_status,
  output logic [7:0]            O_data,
  output logic                  O_valid,
  output logic                  O_frame_err,
  output logic                  O_overrun,
  output logic                  O_busy
);

  localparam int unsigned DW = pDIV_WIDTH;
`ifdef SWO_RX_GLITCH_FILTER_EN
  localparam logic [DW-1:0] DIV_MIN = DW'(2);
`else
  localparam logic [DW-1:0] DIV_MIN = DW'(1);
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

  state_e          state_q, state_d;
  logic            sync1_q, swo_s_q, swo_prev_q;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   div_q, div_d;
  logic [3:0]      nbits_q, nbits_d;
  logic            two_stop_q, two_stop_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic            stop_idx_q, stop_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
  logic            busy_q, busy_d;
  logic [DW-1:0]   div_eff_c;
  logic [DW-1:0]   half_c;
  logic            sample_c;

`ifdef SWO_RX_GLITCH_FILTER_EN
  logic swo_prev2_q;
  always_ff @(posedge uart_clk) begin
    if (reset_i) swo_prev2_q <= 1'b1;
    else         swo_prev2_q <= swo_prev_q;
  end
  assign sample_c = (swo_s_q & swo_prev_q) | (swo_s_q & swo_prev2_q) | (swo_prev_q & swo_prev2_q);
`else
  assign sample_c = swo_s_q;
`endif

  assign div_eff_c = (I_bitrate_div < DIV_MIN) ? DIV_MIN : I_bitrate_div;
  assign half_c    = div_eff_c >> 1;

  // Frame FSM: the start sample lands half a bit after the detected falling edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    nbits_d    = nbits_q;
    two_stop_d = two_stop_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    err_d      = err_q;
    done_d     = 1'b0;
    if (!I_enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!swo_s_q && swo_prev_q) begin
            div_d      = div_eff_c;
            nbits_d    = (I_data_bits >= 4'd5 && I_data_bits <= 4'd8) ? I_data_bits : 4'd8;
            two_stop_d = (I_stop_bits == 2'd2);
            shift_d    = 8'h00;
            err_d      = 1'b0;
            bit_idx_d  = 3'd0;
            stop_idx_d = 1'b0;
            // A zero half-period means the detection cycle itself is the start sample.
            if (half_c == '0) begin
              state_d = ST_DATA;
              cnt_d   = div_eff_c;
            end else begin
              state_d = ST_START;
              cnt_d   = DW'(half_c - DW'(1));
            end
          end
        end
        ST_START: begin
          if (cnt_q != '0) begin
            cnt_d = DW'(cnt_q - DW'(1));
          end else if (sample_c) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            cnt_d     = div_q;
            bit_idx_d = 3'd0;
          end
        end
        ST_DATA: begin
          if (cnt_q != '0) begin
            cnt_d = DW'(cnt_q - DW'(1));
          end else begin
            shift_d[bit_idx_q] = sample_c;
            cnt_d              = div_q;
            if (4'(bit_idx_q) + 4'd1 == nbits_q) begin
              state_d    = ST_STOP;
              stop_idx_d = 1'b0;
            end else begin
              bit_idx_d = 3'(bit_idx_q + 3'd1);
            end
          end
        end
        ST_STOP: begin
          if (cnt_q != '0) begin
            cnt_d = DW'(cnt_q - DW'(1));
          end else begin
            if (!sample_c) err_d = 1'b1;
            cnt_d = div_q;
            if (stop_idx_q == two_stop_q) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              stop_idx_d = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output slot: a handshake frees it; a completed byte either fills it or raises overrun.
  always_comb begin
    data_d  = data_q;
    ferr_d  = ferr_q;
    valid_d = valid_q & ~I_ready;
    ovr_d   = ovr_q & ~I_clear_status;
    busy_d  = (state_d != ST_IDLE);
    if (done_q) begin
      if (valid_q && !I_ready) begin
        ovr_d = 1'b1;
      end else begin
        data_d  = shift_q;
        ferr_d  = err_q;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge uart_clk) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      sync1_q    <= 1'b1;
      swo_s_q    <= 1'b1;
      swo_prev_q <= 1'b1;
      cnt_q      <= '0;
      div_q      <= '0;
      nbits_q    <= 4'd0;
      two_stop_q <= 1'b0;
      bit_idx_q  <= 3'd0;
      stop_idx_q <= 1'b0;
      shift_q    <= 8'h00;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= I_swo;
      swo_s_q    <= sync1_q;
      swo_prev_q <= swo_s_q;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      nbits_q    <= nbits_d;
      two_stop_q <= two_stop_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      err_q      <= err_d;
      done_q     <= done_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
      busy_q     <= busy_d;
    end
  end

  assign O_data      = data_q;
  assign O_valid     = valid_q;
  assign O_frame_err = ferr_q;
  assign O_overrun   = ovr_q;
  assign O_busy      = busy_q;

endmodule

// File: tb/tb_swo_uart_rx.sv
// Directed bench for swo_uart_rx: frame timing, formats, overrun, glitches, enable and reset.
`timescale 1ns/1ps
module tb_swo_uart_rx;

  localparam int unsigned DW = 8;

  logic          uart_clk = 1'b0;
  logic          reset_i;
  logic          I_swo;
  logic          I_enable;
  logic [DW-1:0] I_bitrate_div;
  logic [1:0]    I_stop_bits;
  logic [3:0]    I_data_bits;
  logic          I_ready;
  logic          I_clear_status;
  logic [7:0]    O_data;
  logic          O_valid;
  logic          O_frame_err;
  logic          O_overrun;
  logic          O_busy;

  int n_cmp = 0;
  int n_bad = 0;

  swo_uart_rx #(.pDIV_WIDTH(DW)) dut (
    .uart_clk       (uart_clk),
    .reset_i        (reset_i),
    .I_swo          (I_swo),
    .I_enable       (I_enable),
    .I_bitrate_div  (I_bitrate_div),
    .I_stop_bits    (I_stop_bits),
    .I_data_bits    (I_data_bits),
    .I_ready        (I_ready),
    .I_clear_status (I_clear_status),
    .O_data         (O_data),
    .O_valid        (O_valid),
    .O_frame_err    (O_frame_err),
    .O_overrun      (O_overrun),
    .O_busy         (O_busy)
  );

  always #5 uart_clk = ~uart_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge uart_clk);
  endtask

  // Drives one frame from a negedge; each bit lasts div+1 cycles; glitch_at forces one cycle low.
  task automatic send_frame(input logic [7:0] d, input int nb, input int ns, input int div,
                            input bit last_stop_low, input int glitch_at);
    logic bits [12];
    int   total;
    bits[0] = 1'b0;
    for (int i = 0; i < nb; i++) bits[1+i] = d[i];
    for (int s = 0; s < ns; s++) bits[1+nb+s] = (last_stop_low && s == ns-1) ? 1'b0 : 1'b1;
    total = (1 + nb + ns) * (div + 1);
    for (int c = 0; c < total; c++) begin
      I_swo = (c == glitch_at) ? 1'b0 : bits[c / (div + 1)];
      @(negedge uart_clk);
    end
    I_swo = 1'b1;
  endtask

  task automatic consume();
    I_ready = 1'b1;
    @(negedge uart_clk);
    I_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_i = 1'b1; I_swo = 1'b1; I_enable = 1'b1; I_bitrate_div = 8'd7;
    I_stop_bits = 2'd1; I_data_bits = 4'd8; I_ready = 1'b0; I_clear_status = 1'b0;
    cycles(3);
    reset_i = 1'b0;
    @(negedge uart_clk);
    chk("rst_data", O_data, 0);
    chk("rst_valid", O_valid, 0);
    chk("rst_ferr", O_frame_err, 0);
    chk("rst_ovr", O_overrun, 0);
    chk("rst_busy", O_busy, 0);

    // 8N1 0xA5, div=7: detection two edges after the pin falls, valid after edge t0+76
    fork
      send_frame(8'hA5, 8, 1, 7, 1'b0, -1);
      begin
        repeat (78) @(posedge uart_clk);
        @(negedge uart_clk);
        chk("t1_valid_early", O_valid, 0);
        @(posedge uart_clk);
        @(negedge uart_clk);
        chk("t1_valid_edge", O_valid, 1);
      end
    join
    chk("t1_data", O_data, 8'hA5);
    chk("t1_ferr", O_frame_err, 0);
    chk("t1_busy", O_busy, 0);
    consume();
    chk("t1_hs_valid", O_valid, 0);
    chk("t1_hs_data", O_data, 8'hA5);

    // 8N2 0x3C with second stop low: valid after edge t0+84, framing error
    I_stop_bits = 2'd2;
    fork
      send_frame(8'h3C, 8, 2, 7, 1'b1, -1);
      begin
        repeat (86) @(posedge uart_clk);
        @(negedge uart_clk);
        chk("t2_valid_early", O_valid, 0);
        @(posedge uart_clk);
        @(negedge uart_clk);
        chk("t2_valid_edge", O_valid, 1);
      end
    join
    chk("t2_data", O_data, 8'h3C);
    chk("t2_ferr", O_frame_err, 1);
    consume();
    cycles(4);

    // div=15, 5 data bits 0b10110, then data_bits=12 treated as 8
    I_stop_bits = 2'd1; I_bitrate_div = 8'd15; I_data_bits = 4'd5;
    send_frame(8'h16, 5, 1, 15, 1'b0, -1);
    cycles(4);
    chk("t3_valid5", O_valid, 1);
    chk("t3_data5", O_data, 8'h16);
    chk("t3_ferr5", O_frame_err, 0);
    consume();
    I_data_bits = 4'd12;
    send_frame(8'hC3, 8, 1, 15, 1'b0, -1);
    cycles(4);
    chk("t3_data12", O_data, 8'hC3);
    consume();

    // Overrun with I_ready low, then clear
    I_bitrate_div = 8'd7; I_data_bits = 4'd8;
    send_frame(8'h11, 8, 1, 7, 1'b0, -1);
    cycles(4);
    send_frame(8'h22, 8, 1, 7, 1'b0, -1);
    cycles(4);
    chk("t4_data", O_data, 8'h11);
    chk("t4_valid", O_valid, 1);
    chk("t4_ovr", O_overrun, 1);
    I_clear_status = 1'b1;
    @(negedge uart_clk);
    I_clear_status = 1'b0;
    chk("t4_ovr_clr", O_overrun, 0);
    chk("t4_valid_kept", O_valid, 1);

    // Completion coinciding with a handshake of the pending 0x11
    fork
      send_frame(8'h33, 8, 1, 7, 1'b0, -1);
      begin
        repeat (78) @(posedge uart_clk);
        @(negedge uart_clk);
        I_ready = 1'b1;
        @(negedge uart_clk);
        I_ready = 1'b0;
        chk("t7_valid", O_valid, 1);
        chk("t7_data", O_data, 8'h33);
        chk("t7_ovr", O_overrun, 0);
      end
    join
    consume();
    chk("t7_drained", O_valid, 0);

    // 2-cycle low glitch on idle line aborts in START
    I_swo = 1'b0;
    cycles(2);
    I_swo = 1'b1;
    cycles(1);
    chk("t5_busy_start", O_busy, 1);
    cycles(10);
    chk("t5_busy_abort", O_busy, 0);
    chk("t5_no_valid", O_valid, 0);

    // Line stuck low: one all-zero frame with framing error, then no further starts
    I_swo = 1'b0;
    cycles(120);
    chk("stuck_valid", O_valid, 1);
    chk("stuck_data", O_data, 8'h00);
    chk("stuck_ferr", O_frame_err, 1);
    consume();
    cycles(100);
    chk("stuck_no_restart", O_valid, 0);
    chk("stuck_idle", O_busy, 0);
    I_swo = 1'b1;
    cycles(10);

    // Enable dropped during data bit 4; then re-enable and receive 0x5A
    fork
      send_frame(8'h5A, 8, 1, 7, 1'b0, -1);
      begin
        repeat (36) @(posedge uart_clk);
        @(negedge uart_clk);
        chk("t6_busy_pre", O_busy, 1);
        I_enable = 1'b0;
        @(negedge uart_clk);
        chk("t6_busy_off", O_busy, 0);
      end
    join
    cycles(4);
    chk("t6_no_valid", O_valid, 0);
    I_enable = 1'b1;
    cycles(4);
    send_frame(8'h5A, 8, 1, 7, 1'b0, -1);
    cycles(4);
    chk("t6_valid", O_valid, 1);
    chk("t6_data", O_data, 8'h5A);
    consume();

    // Reset mid-frame drops everything, including the last delivered byte
    fork
      send_frame(8'hFF, 8, 1, 7, 1'b0, -1);
      begin
        repeat (30) @(posedge uart_clk);
        @(negedge uart_clk);
        reset_i = 1'b1;
        @(negedge uart_clk);
        reset_i = 1'b0;
        chk("rst_mid_busy", O_busy, 0);
        chk("rst_mid_data", O_data, 0);
      end
    join
    cycles(20);
    chk("rst_mid_no_valid", O_valid, 0);

`ifdef SWO_RX_GLITCH_FILTER_EN
    // 1-cycle low glitch at the sample point of data bit 3 is voted out
    send_frame(8'hFF, 8, 1, 7, 1'b0, 35);
    cycles(4);
    chk("gf_valid", O_valid, 1);
    chk("gf_data", O_data, 8'hFF);
    consume();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
